// File: rtl/arbiter2_leaf_pkg.sv
// Shared NoC definitions for the tree merge/split nodes: packet width,
// address field position and the packet type.
package arbiter2_leaf_pkg;

   localparam int PKT_W    = 9;
   localparam int ADDR_MSB = 8;
   localparam int ADDR_LSB = 5;

   typedef logic [PKT_W-1:0]         pkt_t;
   typedef logic [ADDR_MSB-ADDR_LSB:0] addr_t;

   function automatic addr_t pkt_addr(input pkt_t p);
      return p[ADDR_MSB:ADDR_LSB];
   endfunction

   function automatic logic pkt_parity(input pkt_t p);
      return ^p;
   endfunction

endpackage

// File: rtl/arbiter2_leaf_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from req and
// the held priority; priority moves past the winner only when advance is set.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic       prio_r;
   logic [1:0] gnt_s;

   // Pick the sole requester, or the one named by prio on contention
   always_comb begin
      gnt_s = 2'b00;
      case (req)
         2'b01:   gnt_s = 2'b01;
         2'b10:   gnt_s = 2'b10;
         2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
         default: gnt_s = 2'b00;
      endcase
   end

   assign gnt = gnt_s;

   // Hand priority to the other requester after each consumed grant
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_r <= 1'b0;
      end else if (advance && gnt_s[1]) begin
         prio_r <= 1'b0;
      end else if (advance && gnt_s[0]) begin
         prio_r <= 1'b1;
      end else begin
         prio_r <= prio_r;
      end
   end

endmodule

// File: rtl/arbiter2_leaf.sv
// Two-child merge node: forwards one packet per cycle to the parent and emits
// a select token naming the child it came from.
module arbiter2_leaf
   import arbiter2_leaf_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic in0_valid,
   output logic in0_ready,
   input  pkt_t in0_data,
   input  logic in1_valid,
   output logic in1_ready,
   input  pkt_t in1_data,
   output logic out_valid,
   input  logic out_ready,
   output pkt_t out_data,
   output logic s_valid,
   input  logic s_ready,
   output logic s_data
);

   logic       accept_s;
   logic       advance_s;
   logic [1:0] req_s;
   logic [1:0] gnt_s;
   logic       out_valid_r;
   pkt_t       out_data_r;
   logic       s_valid_r;
   logic       s_data_r;

   assign req_s = {in1_valid, in0_valid};

   // Packet and token travel together, so both slots must be free or draining
   always_comb begin
      accept_s = 1'b0;
      if (reset) begin
         accept_s = 1'b0;
      end else begin
         accept_s = (!out_valid_r || out_ready) && (!s_valid_r || s_ready);
      end
   end

   assign in0_ready = accept_s && gnt_s[0];
   assign in1_ready = accept_s && gnt_s[1];
   assign advance_s = accept_s && (gnt_s != 2'b00);

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_s),
      .advance (advance_s),
      .gnt     (gnt_s)
   );

   // Load packet and token together; otherwise each slot drains on its own
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         s_valid_r   <= 1'b0;
         s_data_r    <= 1'b0;
      end else if (advance_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= gnt_s[1] ? in1_data : in0_data;
         s_valid_r   <= 1'b1;
         s_data_r    <= gnt_s[1];
      end else begin
         out_valid_r <= out_ready ? 1'b0 : out_valid_r;
         out_data_r  <= out_data_r;
         s_valid_r   <= s_ready ? 1'b0 : s_valid_r;
         s_data_r    <= s_data_r;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign s_valid   = s_valid_r;
   assign s_data    = s_data_r;

endmodule

// File: tb/tb_arbiter2_leaf.sv
// Directed vectors for arbiter2_leaf plus a randomized valid/ready stress
// checked against an independent behavioural model.
module tb_arbiter2_leaf;

   logic       clk = 1'b0;
   logic       reset;
   logic       in0_valid, in0_ready, in1_valid, in1_ready;
   logic [8:0] in0_data, in1_data, out_data;
   logic       out_valid, out_ready, s_valid, s_ready, s_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] exp2 [0:7];
   int         i0, i1;
   logic       r0, r1;

   logic       m_ov, m_sv, m_sd, m_prio, m_acc, m_g0, m_g1;
   logic [8:0] m_od, d0, d1;
   logic       v0, v1, or_s, sr_s;
   int         seq0, seq1, issued, sent, rx, cyc;

   always #5 clk = ~clk;

   arbiter2_leaf dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v0_i, input logic [8:0] d0_i, input logic v1_i,
                        input logic [8:0] d1_i, input logic or_i, input logic sr_i);
      in0_valid = v0_i;
      in0_data  = d0_i;
      in1_valid = v1_i;
      in1_data  = d1_i;
      out_ready = or_i;
      s_ready   = sr_i;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1);
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      exp2[0] = 9'h101; exp2[1] = 9'h1F1; exp2[2] = 9'h102; exp2[3] = 9'h1F2;
      exp2[4] = 9'h103; exp2[5] = 9'h1F3; exp2[6] = 9'h104; exp2[7] = 9'h1F4;

      // reset state, readies held low during reset even with free slots
      reset = 1'b1;
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1);
      @(negedge clk);
      tick();
      drive(1'b1, 9'h0AA, 1'b1, 9'h155, 1'b1, 1'b1);
      #1;
      check_eq("rst_state", 32'({out_valid, s_valid, out_data, s_data}), 32'h0);
      check_eq("rst_rdy", 32'({in1_ready, in0_ready}), 32'h0);
      tick();
      reset = 1'b0;

      // single packet from in0
      drive(1'b1, 9'h1A5, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t1_rdy", 32'({in1_ready, in0_ready}), 32'h1);
      tick();
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t1_out", 32'({out_valid, out_data}), 32'h3A5);
      check_eq("t1_sel", 32'({s_valid, s_data}), 32'h2);
      check_eq("t1_rdy1", 32'(in1_ready), 32'h0);
      tick();
      #1;
      check_eq("t1_drain", 32'({out_valid, s_valid}), 32'h0);

      // both children continuously valid: alternating grants, 1 pkt/cycle
      do_reset();
      i0 = 0;
      i1 = 0;
      for (int c = 0; c < 9; c++) begin
         drive(i0 < 4, 9'h101 + 9'(i0), i1 < 4, 9'h1F1 + 9'(i1), 1'b1, 1'b1);
         #1;
         if (c < 8) check_eq("t2_gnt", 32'({in1_ready, in0_ready}), (c % 2 == 0) ? 32'h1 : 32'h2);
         if (c > 0) begin
            check_eq("t2_out", 32'({out_valid, out_data}), 32'({1'b1, exp2[c-1]}));
            check_eq("t2_sel", 32'({s_valid, s_data}), ((c - 1) % 2 == 0) ? 32'h2 : 32'h3);
         end
         r0 = in0_ready;
         r1 = in1_ready;
         tick();
         if (r0) i0++;
         if (r1) i1++;
      end

      // out stalled 3 cycles, token drains, no new accepts until out drains
      do_reset();
      drive(1'b1, 9'h0A1, 1'b0, 9'h000, 1'b1, 1'b1);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 9'h0A2, 1'b1, 9'h1B1, 1'b0, 1'b1);
         #1;
         check_eq("t3_hold", 32'({out_valid, out_data}), 32'h2A1);
         check_eq("t3_rdy", 32'({in1_ready, in0_ready}), 32'h0);
         if (c > 0) check_eq("t3_sdrain", 32'(s_valid), 32'h0);
         tick();
      end
      drive(1'b1, 9'h0A2, 1'b1, 9'h1B1, 1'b1, 1'b1);
      #1;
      check_eq("t3_rdy_go", 32'({in1_ready, in0_ready}), 32'h2);
      tick();
      drive(1'b1, 9'h0A2, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t3_out1", 32'({out_valid, out_data}), 32'h3B1);
      check_eq("t3_sel1", 32'({s_valid, s_data}), 32'h3);
      check_eq("t3_rdy2", 32'({in1_ready, in0_ready}), 32'h1);
      tick();
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t3_out2", 32'({out_valid, out_data}), 32'h2A2);
      check_eq("t3_sel2", 32'({s_valid, s_data}), 32'h2);
      tick();

      // token stalled: out drains, next packet waits for token consumer
      do_reset();
      drive(1'b1, 9'h0C1, 1'b0, 9'h000, 1'b1, 1'b1);
      tick();
      drive(1'b1, 9'h0C2, 1'b1, 9'h1D1, 1'b1, 1'b0);
      #1;
      check_eq("t4_out", 32'({out_valid, out_data}), 32'h2C1);
      check_eq("t4_rdy", 32'({in1_ready, in0_ready}), 32'h0);
      tick();
      #1;
      check_eq("t4_split", 32'({out_valid, s_valid, s_data}), 32'h2);
      check_eq("t4_rdy_s", 32'({in1_ready, in0_ready}), 32'h0);
      tick();
      drive(1'b1, 9'h0C2, 1'b1, 9'h1D1, 1'b1, 1'b1);
      #1;
      check_eq("t4_rdy_go", 32'({in1_ready, in0_ready}), 32'h2);
      tick();
      drive(1'b1, 9'h0C2, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t4_out1", 32'({out_valid, out_data}), 32'h3D1);
      check_eq("t4_sel1", 32'({s_valid, s_data}), 32'h3);
      tick();
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t4_out2", 32'({out_valid, out_data}), 32'h2C2);
      check_eq("t4_sel2", 32'({s_valid, s_data}), 32'h2);
      tick();

      // reset with both slots full and priority on in1
      do_reset();
      drive(1'b1, 9'h011, 1'b0, 9'h000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0);
      #1;
      check_eq("t5_full", 32'({out_valid, s_valid, out_data}), 32'h611);
      tick();
      reset = 1'b1;
      drive(1'b1, 9'h022, 1'b1, 9'h133, 1'b1, 1'b1);
      #1;
      check_eq("t5_rdy_rst", 32'({in1_ready, in0_ready}), 32'h0);
      tick();
      reset = 1'b0;
      #1;
      check_eq("t5_empty", 32'({out_valid, s_valid}), 32'h0);
      check_eq("t5_gnt", 32'({in1_ready, in0_ready}), 32'h1);
      tick();
      drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1);
      #1;
      check_eq("t5_out", 32'({out_valid, out_data}), 32'h222);
      check_eq("t5_sel", 32'({s_valid, s_data}), 32'h2);
      tick();

      // random stress against a behavioural model
      do_reset();
      m_ov = 1'b0; m_sv = 1'b0; m_sd = 1'b0; m_prio = 1'b0; m_od = 9'h000;
      v0 = 1'b0; v1 = 1'b0; d0 = 9'h000; d1 = 9'h000;
      seq0 = 0; seq1 = 0; issued = 0; sent = 0; rx = 0; cyc = 0;
      while (!(sent == 10000 && !m_ov && !m_sv) && cyc < 60000) begin
         if (!v0 && issued < 10000 && $urandom_range(0, 9) < 6) begin
            v0 = 1'b1;
            d0 = {1'b0, seq0[7:0]};
            issued++;
         end
         if (!v1 && issued < 10000 && $urandom_range(0, 9) < 6) begin
            v1 = 1'b1;
            d1 = {1'b1, seq1[7:0]};
            issued++;
         end
         or_s = ($urandom_range(0, 3) != 0);
         sr_s = ($urandom_range(0, 3) != 0);
         drive(v0, d0, v1, d1, or_s, sr_s);
         #1;
         m_acc = (!m_ov || or_s) && (!m_sv || sr_s);
         m_g0  = m_acc && v0 && (!v1 || !m_prio);
         m_g1  = m_acc && v1 && (!v0 || m_prio);
         check_eq("st_ctl", 32'({out_valid, s_valid, in1_ready, in0_ready}),
                  32'({m_ov, m_sv, m_g1, m_g0}));
         if (m_ov && or_s) begin
            check_eq("st_out", 32'(out_data), 32'(m_od));
            rx++;
         end
         if (m_sv && sr_s) check_eq("st_sel", 32'(s_data), 32'(m_sd));
         tick();
         cyc++;
         if (m_g0 || m_g1) begin
            m_od   = m_g1 ? d1 : d0;
            m_sd   = m_g1;
            m_ov   = 1'b1;
            m_sv   = 1'b1;
            m_prio = !m_g1;
         end else begin
            if (or_s) m_ov = 1'b0;
            if (sr_s) m_sv = 1'b0;
         end
         if (m_g0) begin v0 = 1'b0; seq0++; sent++; end
         if (m_g1) begin v1 = 1'b0; seq1++; sent++; end
      end
      check_eq("st_timeout", 32'(cyc < 60000), 32'h1);
      check_eq("st_count", 32'(rx), 32'd10000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
